gemm_out_pack: RTL and testbench

- Downstream of the combinational GEMM core: accepts one 16-lane ACC_WIDTH result tensor (o_tensor packing) per valid/ready handshake.
- Requantizes each lane: arithmetic right shift, then signed saturation to OUT_WIDTH.
- Emits the result as a valid/ready stream of LANES-wide beats toward the output/store buffer.
- Frees the core's output register as soon as the tensor is captured.

---
 rtl/gemm_pkg.sv | 16 +
 rtl/gemm_quant_lane.sv | 53 +++++
 rtl/gemm_out_pack.sv | 138 +++++++++++++
 tb/tb_gemm_out_pack.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// Shared constants and lane types for the GEMM output path.
package gemm_pkg;

  localparam int unsigned ACC_WIDTH = 32;
  localparam int unsigned OUT_WIDTH = 8;
  localparam int unsigned INP_DEPTH = 16;
  localparam int unsigned LANES     = 4;
  localparam int unsigned SHIFT_W   = 5;

  typedef logic signed [ACC_WIDTH-1:0] acc_t;
  typedef logic signed [OUT_WIDTH-1:0] out_t;

  localparam out_t SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam out_t SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

endpackage

// File: rtl/gemm_quant_lane.sv
// One requantization lane: clamp shift, optional round-half-up, arithmetic
// right shift, signed saturation to OUT_W, plus the lane's saturation flag.
// Ports: acc (two's complement accumulator), shift (raw shift amount),
//        q_c (saturated result), sat_c (lane saturated).
// Build option: GEMM_OUT_ROUND_EN adds 2^(shift-1) before the shift.
module gemm_quant_lane
  import gemm_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_WIDTH,
  parameter int unsigned OUT_W = OUT_WIDTH,
  parameter int unsigned SH_W  = SHIFT_W
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [SH_W-1:0]  shift,
  output logic [OUT_W-1:0] q_c,
  output logic             sat_c
);

  // One extra bit so the rounding add can never wrap.
  localparam int unsigned EXT_W = ACC_W + 1;
  localparam logic signed [EXT_W-1:0] HI = EXT_W'((64'd1 << (OUT_W-1)) - 64'd1);
  localparam logic signed [EXT_W-1:0] LO = ~HI;

  logic [31:0]             sh;
  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] sum;
  logic signed [EXT_W-1:0] shifted;

  assign sh  = (32'(shift) > (ACC_W - 32'd1)) ? (ACC_W - 32'd1) : 32'(shift);
  assign ext = {acc[ACC_W-1], acc};

`ifdef GEMM_OUT_ROUND_EN
  assign sum = (sh == 32'd0) ? ext : ext + (EXT_W'(1) << (sh - 32'd1));
`else
  assign sum = ext;
`endif

  assign shifted = sum >>> sh;

  // Saturate to the signed output range.
  always_comb begin
    q_c   = shifted[OUT_W-1:0];
    sat_c = 1'b0;
    if (shifted > HI) begin
      q_c   = {1'b0, {(OUT_W-1){1'b1}}};
      sat_c = 1'b1;
    end else if (shifted < LO) begin
      q_c   = {1'b1, {(OUT_W-1){1'b0}}};
      sat_c = 1'b1;
    end
  end

endmodule

// File: rtl/gemm_out_pack.sv
// Captures one DEPTH-lane accumulator tensor, requantizes it LANES lanes at a
// time and streams BEATS beats downstream. s_ready frees the core as soon as
// the tensor is captured.
// Ports: clk, rst_n (async active-low); s_valid/s_ready/s_tensor/s_shift
//        input tensor handshake; m_valid/m_ready/m_data/m_last/m_sat beat
//        stream. All outputs are registered.
// Build option: GEMM_OUT_ROUND_EN enables round-half-up in each lane.
module gemm_out_pack
  import gemm_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = gemm_pkg::ACC_WIDTH,
  parameter int unsigned OUT_WIDTH = gemm_pkg::OUT_WIDTH,
  parameter int unsigned DEPTH     = gemm_pkg::INP_DEPTH,
  parameter int unsigned LANES     = gemm_pkg::LANES,
  parameter int unsigned SHIFT_W   = gemm_pkg::SHIFT_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [ACC_WIDTH*DEPTH-1:0]   s_tensor,
  input  logic [SHIFT_W-1:0]           s_shift,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [OUT_WIDTH*LANES-1:0]   m_data,
  output logic                         m_last,
  output logic                         m_sat
);

  localparam int unsigned BEATS  = DEPTH / LANES;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned TEN_W  = ACC_WIDTH * DEPTH;
  localparam int unsigned DAT_W  = OUT_WIDTH * LANES;

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state, state_nxt;
  logic [BEAT_W-1:0]   beat, beat_nxt, sel_beat;
  logic [TEN_W-1:0]    cap_tensor, src_tensor;
  logic [SHIFT_W-1:0]  cap_shift, src_shift;
  logic                cap_ld, out_ld;
  logic [DAT_W-1:0]    data_nxt;
  logic                last_nxt, sat_nxt;

  logic [ACC_WIDTH-1:0] lane_acc [LANES];
  logic [OUT_WIDTH-1:0] lane_q   [LANES];
  logic [LANES-1:0]     lane_sat;

  // Next-state: the beat presented next is quantized one cycle ahead so that
  // m_data is a plain register. On capture the lanes read the input directly.
  always_comb begin
    state_nxt  = state;
    beat_nxt   = beat;
    cap_ld     = 1'b0;
    out_ld     = 1'b0;
    sel_beat   = beat + BEAT_W'(1);
    src_tensor = cap_tensor;
    src_shift  = cap_shift;
    case (state)
      IDLE: begin
        if (s_valid) begin
          state_nxt  = SEND;
          beat_nxt   = '0;
          cap_ld     = 1'b1;
          out_ld     = 1'b1;
          sel_beat   = '0;
          src_tensor = s_tensor;
          src_shift  = s_shift;
        end
      end
      SEND: begin
        if (m_ready) begin
          if (beat == BEAT_W'(BEATS - 1)) begin
            state_nxt = IDLE;
          end else begin
            beat_nxt = beat + BEAT_W'(1);
            out_ld   = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat-selected lane fan-out and result packing.
  always_comb begin
    data_nxt = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      lane_acc[k] = src_tensor[(int'(sel_beat) * int'(LANES) + k) * int'(ACC_WIDTH) +: ACC_WIDTH];
      data_nxt[k*OUT_WIDTH +: OUT_WIDTH] = lane_q[k];
    end
    last_nxt = (sel_beat == BEAT_W'(BEATS - 1));
    sat_nxt  = |lane_sat;
  end

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    gemm_quant_lane #(
      .ACC_W(ACC_WIDTH),
      .OUT_W(OUT_WIDTH),
      .SH_W (SHIFT_W)
    ) u_lane (
      .acc  (lane_acc[g]),
      .shift(src_shift),
      .q_c  (lane_q[g]),
      .sat_c(lane_sat[g])
    );
  end

  // State, capture and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat       <= '0;
      cap_tensor <= '0;
      cap_shift  <= '0;
      s_ready    <= 1'b1;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      m_sat      <= 1'b0;
    end else begin
      state   <= state_nxt;
      beat    <= beat_nxt;
      s_ready <= (state_nxt == IDLE);
      m_valid <= (state_nxt == SEND);
      if (cap_ld) begin
        cap_tensor <= s_tensor;
        cap_shift  <= s_shift;
      end
      if (out_ld) begin
        m_data <= data_nxt;
        m_last <= last_nxt;
        m_sat  <= sat_nxt;
      end
    end
  end

endmodule

// File: tb/tb_gemm_out_pack.sv
module tb_gemm_out_pack;

  localparam int ACC = 32;
  localparam int OW  = 8;
  localparam int DEP = 16;
  localparam int LN  = 4;
  localparam int NB  = DEP / LN;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s_valid;
  logic             s_ready;
  logic [ACC*DEP-1:0] s_tensor;
  logic [4:0]       s_shift;
  logic             m_valid;
  logic             m_ready;
  logic [OW*LN-1:0] m_data;
  logic             m_last;
  logic             m_sat;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gemm_out_pack dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_tensor(s_tensor),
    .s_shift (s_shift),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_sat   (m_sat)
  );

  // Reference quantizer: plain integer arithmetic on a 64-bit value.
  function automatic longint ref_q(input logic [ACC-1:0] a, input int sh_in);
    longint v;
    int     sh;
    sh = (sh_in > ACC - 1) ? ACC - 1 : sh_in;
    v  = longint'($signed(a));
`ifdef GEMM_OUT_ROUND_EN
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
`endif
    v = v >>> sh;
    return v;
  endfunction

  function automatic logic [OW*LN-1:0] exp_data(input logic [ACC*DEP-1:0] t, input int sh, input int b);
    logic [OW*LN-1:0] d;
    longint v;
    d = '0;
    for (int k = 0; k < LN; k++) begin
      v = ref_q(t[(b*LN+k)*ACC +: ACC], sh);
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      d[k*OW +: OW] = 8'(v);
    end
    return d;
  endfunction

  function automatic logic exp_sat(input logic [ACC*DEP-1:0] t, input int sh, input int b);
    longint v;
    logic   s;
    s = 1'b0;
    for (int k = 0; k < LN; k++) begin
      v = ref_q(t[(b*LN+k)*ACC +: ACC], sh);
      if (v > 127 || v < -128) s = 1'b1;
    end
    return s;
  endfunction

  // Send one tensor and check every beat; optional stalls and an ignored
  // s_valid pulse (with a different tensor) while stalled.
  task automatic xfer(input logic [ACC*DEP-1:0] t, input logic [4:0] sh,
                      input int max_stall, input bit poke, input string tag);
    logic [OW*LN-1:0] d;
    int stalls;
    @(negedge clk);
    n_checks++;
    if (s_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s s_ready_idle got %b want 1", tag, s_ready);
    end
    s_tensor = t; s_shift = sh; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    for (int b = 0; b < NB; b++) begin
      d = exp_data(t, int'(sh), b);
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== d || m_last !== (b == NB - 1) ||
          m_sat !== exp_sat(t, int'(sh), b) || s_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s beat%0d got v=%b d=%h l=%b s=%b rdy=%b want v=1 d=%h l=%b s=%b rdy=0",
                 tag, b, m_valid, m_data, m_last, m_sat, s_ready, d, (b == NB - 1),
                 exp_sat(t, int'(sh), b));
      end
      stalls = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
      if (max_stall < 0 && b == 1) stalls = 3;
      for (int i = 0; i < stalls; i++) begin
        m_ready = 1'b0;
        if (poke) begin
          s_valid = 1'b1; s_tensor = ~t; s_shift = 5'd0;
        end
        @(negedge clk);
        s_valid = 1'b0;
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== d || m_last !== (b == NB - 1)) begin
          n_fail++;
          $display("FAIL %s hold beat%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   tag, b, m_valid, m_data, m_last, d, (b == NB - 1));
        end
      end
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
    end
    n_checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s after_last got rdy=%b v=%b want rdy=1 v=0", tag, s_ready, m_valid);
    end
  endtask

  function automatic logic [ACC*DEP-1:0] pack1(input logic [ACC-1:0] l0, input logic [ACC-1:0] l1,
                                               input logic [ACC-1:0] l2);
    logic [ACC*DEP-1:0] t;
    t = '0;
    t[0 +: ACC] = l0; t[ACC +: ACC] = l1; t[2*ACC +: ACC] = l2;
    return t;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_tensor = '0; s_shift = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0 || m_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL reset got rdy=%b v=%b d=%h l=%b s=%b want 1 0 0 0 0", s_ready, m_valid, m_data, m_last, m_sat);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ramp();
    logic [ACC*DEP-1:0] t;
    logic [31:0] b0;
    for (int m = 0; m < DEP; m++) t[m*ACC +: ACC] = 32'(m);
    b0 = exp_data(t, 0, 0);
    n_checks++;
    if (b0 !== 32'h03020100) begin
      n_fail++; $display("FAIL ramp_model got %h want 03020100", b0);
    end
    xfer(t, 5'd0, 0, 1'b0, "ramp");
  endtask

  task automatic test_saturation();
    xfer(pack1(32'h00001000, 32'hFFFFF000, 32'h00000070), 5'd4, 0, 1'b0, "sat");
  endtask

  task automatic test_rounding();
    xfer(pack1(32'd5, -32'sd5, 32'd0), 5'd1, 0, 1'b0, "round");
  endtask

  task automatic test_clamp();
    xfer(pack1(32'h80000000, 32'h7FFFFFFF, 32'h00000001), 5'd31, 0, 1'b0, "clamp");
  endtask

  task automatic test_backpressure();
    logic [ACC*DEP-1:0] t;
    for (int m = 0; m < DEP; m++) t[m*ACC +: ACC] = $urandom;
    xfer(t, 5'd20, -1, 1'b1, "bp");
  endtask

  task automatic test_mid_reset();
    logic [ACC*DEP-1:0] t;
    for (int m = 0; m < DEP; m++) t[m*ACC +: ACC] = 32'(m * 3);
    @(negedge clk);
    s_tensor = t; s_shift = 5'd0; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    m_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_valid got %b want 0", m_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_release got rdy=%b v=%b want 1 0", s_ready, m_valid);
    end
    for (int m = 0; m < DEP; m++) t[m*ACC +: ACC] = 32'(100 + m);
    xfer(t, 5'd0, 0, 1'b0, "post_rst");
  endtask

  task automatic test_random();
    logic [ACC*DEP-1:0] t;
    for (int n = 0; n < 8; n++) begin
      for (int m = 0; m < DEP; m++) t[m*ACC +: ACC] = $urandom >> $urandom_range(0, 31);
      for (int m = 0; m < DEP; m++) if ($urandom_range(0, 1) == 1) t[m*ACC +: ACC] = -t[m*ACC +: ACC];
      xfer(t, 5'($urandom_range(0, 31)), 2, 1'b0, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_saturation();
    test_rounding();
    test_clamp();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
